// File: rtl/match_indirection_table.sv
// Indirection table between the lookup CAM and the action RAM. It maps a CAM hit address to an
// action-RAM address and is programmed in-band through the control AXI-Stream.
module match_indirection_table #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PHV_LEN              = 4*8*64+256,
    parameter int STAGE_ID             = 0,
    parameter int INDIRECTION_ID       = 6,
    parameter int SUB_UNIT_ID          = 1,
    parameter int ADDR_W               = 8,
    parameter int DATA_W               = 8,
    parameter logic [DATA_W-1:0] MISS_VALUE = '1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic [ADDR_W-1:0]                 match_addr_in,
    input  logic                              if_match_in,
    input  logic                              valid_in,
    output logic                              ready_out,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic [DATA_W-1:0]                 act_addr_out,
    output logic                              if_match_out,
    output logic                              valid_out,
    input  logic                              ready_in,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PARSE   = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_DROP    = 3'd3;
    localparam logic [2:0] ST_FLUSH   = 3'd4;

    // bit DATA_W of each word is the entry-valid flag
    logic [DATA_W:0]       mem [DEPTH];
    logic [DATA_W:0]       rd_data_q;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [DATA_W:0]       ram_wdata;

    logic                  adv, ready, hit;
    logic                  s1_valid_q, s1_valid_d, s1_match_q, s1_match_d;
    logic [PHV_LEN-1:0]    s1_phv_q, s1_phv_d, phv_out_q, phv_out_d;
    logic                  valid_out_q, valid_out_d, if_match_out_q, if_match_out_d;
    logic [DATA_W-1:0]     act_addr_q, act_addr_d;

    logic [2:0]            state_q, state_d;
    logic [DW-1:0]         seg1_data_q, seg1_data_d, d1_data_q, d1_data_d, cm_data_q, cm_data_d;
    logic [UW-1:0]         seg1_user_q, seg1_user_d, d1_user_q, d1_user_d, cm_user_q, cm_user_d;
    logic [KW-1:0]         seg1_keep_q, seg1_keep_d, d1_keep_q, d1_keep_d, cm_keep_q, cm_keep_d;
    logic                  seg1_last_q, seg1_last_d, d1_last_q, d1_last_d, cm_last_q, cm_last_d;
    logic                  d1_valid_q, d1_valid_d, cm_valid_q, cm_valid_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic                  ctl_we, clr_start, sweep_we;
    logic [ADDR_W-1:0]     ctl_waddr;
    logic [DATA_W:0]       ctl_wdata;
    logic                  clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;

    logic [7:0]            mod_id;
    logic [3:0]            resv, sub_unit_id;
    logic [15:0]           control_flag;
    logic [ADDR_W-1:0]     index;
    logic                  claimed;
    logic [DATA_W-1:0]     entry;

    // lookup pipeline: one global advance, every stage holds together under backpressure
    always_comb begin
        adv            = ready_in | ~valid_out_q;
        ready          = adv & ~clr_busy_q;
        hit            = s1_match_q & rd_data_q[DATA_W];
        s1_valid_d     = s1_valid_q;
        s1_match_d     = s1_match_q;
        s1_phv_d       = s1_phv_q;
        valid_out_d    = valid_out_q;
        if_match_out_d = if_match_out_q;
        act_addr_d     = act_addr_q;
        phv_out_d      = phv_out_q;
        if (adv) begin
            s1_valid_d     = valid_in & ready;
            s1_match_d     = if_match_in;
            s1_phv_d       = phv_in;
            valid_out_d    = s1_valid_q;
            if_match_out_d = hit;
            act_addr_d     = hit ? rd_data_q[DATA_W-1:0] : MISS_VALUE;
            phv_out_d      = s1_phv_q;
        end
    end

    always_comb begin
        mod_id       = c_s_axis_tdata[112 +: 8];
        resv         = c_s_axis_tdata[120 +: 4];
        sub_unit_id  = c_s_axis_tdata[124 +: 4];
        control_flag = c_s_axis_tdata[64 +: 16];
        index        = c_s_axis_tdata[128 +: ADDR_W];
        claimed      = (control_flag == 16'hf2f1) && (mod_id[7:3] == 5'(STAGE_ID)) &&
                       (mod_id[2:0] == 3'(INDIRECTION_ID)) && (sub_unit_id == 4'(SUB_UNIT_ID)) &&
                       (resv != 4'd0);
        // first payload byte lands in the most significant byte of the entry
        entry = '0;
        for (int i = 0; i < NB; i++) entry[i*8 +: 8] = c_s_axis_tdata[(NB-1-i)*8 +: 8];
    end

    always_comb begin
        state_d     = state_q;
        seg1_data_d = seg1_data_q;
        seg1_user_d = seg1_user_q;
        seg1_keep_d = seg1_keep_q;
        seg1_last_d = seg1_last_q;
        d1_valid_d  = c_s_axis_tvalid;
        d1_data_d   = c_s_axis_tdata;
        d1_user_d   = c_s_axis_tuser;
        d1_keep_d   = c_s_axis_tkeep;
        d1_last_d   = c_s_axis_tlast;
        cm_valid_d  = 1'b0;
        cm_data_d   = cm_data_q;
        cm_user_d   = cm_user_q;
        cm_keep_d   = cm_keep_q;
        cm_last_d   = cm_last_q;
        idx_d       = idx_q;
        ctl_we      = 1'b0;
        ctl_waddr   = idx_q;
        ctl_wdata   = '0;
        clr_start   = 1'b0;
        case (state_q)
            ST_IDLE: if (c_s_axis_tvalid) begin
                seg1_data_d = c_s_axis_tdata;
                seg1_user_d = c_s_axis_tuser;
                seg1_keep_d = c_s_axis_tkeep;
                seg1_last_d = c_s_axis_tlast;
                state_d     = ST_PARSE;
            end
            ST_PARSE: if (c_s_axis_tvalid) begin
                if (claimed) begin
                    state_d = c_s_axis_tlast ? ST_IDLE : ST_DROP;
                    case (resv)
                        4'd1: begin
                            idx_d = index;
                            if (!c_s_axis_tlast) state_d = ST_WR_DATA;
                        end
                        4'd2: begin
                            ctl_we    = 1'b1;
                            ctl_waddr = index;
                        end
                        4'd15:   clr_start = 1'b1;
                        default: ;
                    endcase
                end else begin
                    cm_valid_d = 1'b1;
                    cm_data_d  = seg1_data_q;
                    cm_user_d  = seg1_user_q;
                    cm_keep_d  = seg1_keep_q;
                    cm_last_d  = seg1_last_q;
                    state_d    = ST_FLUSH;
                end
            end
            ST_WR_DATA: if (c_s_axis_tvalid) begin
                ctl_we    = 1'b1;
                ctl_wdata = {1'b1, entry};
                state_d   = c_s_axis_tlast ? ST_IDLE : ST_DROP;
            end
            ST_DROP: if (c_s_axis_tvalid && c_s_axis_tlast) state_d = ST_IDLE;
            ST_FLUSH: if (d1_valid_q) begin
                cm_valid_d = 1'b1;
                cm_data_d  = d1_data_q;
                cm_user_d  = d1_user_q;
                cm_keep_d  = d1_keep_q;
                cm_last_d  = d1_last_q;
                if (d1_last_q) begin
                    state_d = ST_IDLE;
                    // a packet may start right behind the tail being emitted
                    if (c_s_axis_tvalid) begin
                        seg1_data_d = c_s_axis_tdata;
                        seg1_user_d = c_s_axis_tuser;
                        seg1_keep_d = c_s_axis_tkeep;
                        seg1_last_d = c_s_axis_tlast;
                        state_d     = ST_PARSE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // control writes own the write port; the sweep stalls in place for that cycle
    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_cnt_d  = clr_cnt_q;
        sweep_we   = 1'b0;
        if (clr_start) begin
            clr_busy_d = 1'b1;
            clr_cnt_d  = '0;
        end else if (clr_busy_q && !ctl_we) begin
            sweep_we  = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(DEPTH-1)) clr_busy_d = 1'b0;
        end
        ram_we    = ctl_we | sweep_we;
        ram_waddr = ctl_we ? ctl_waddr : clr_cnt_q;
        ram_wdata = ctl_we ? ctl_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (ram_we && !rst) mem[ram_waddr] <= ram_wdata;
        if (adv) rd_data_q <= mem[match_addr_in];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0; s1_match_q <= 1'b0; s1_phv_q <= '0;
            valid_out_q <= 1'b0; if_match_out_q <= 1'b0; act_addr_q <= '0; phv_out_q <= '0;
            state_q <= ST_IDLE; idx_q <= '0;
            seg1_data_q <= '0; seg1_user_q <= '0; seg1_keep_q <= '0; seg1_last_q <= 1'b0;
            d1_valid_q <= 1'b0; d1_data_q <= '0; d1_user_q <= '0; d1_keep_q <= '0; d1_last_q <= 1'b0;
            cm_valid_q <= 1'b0; cm_data_q <= '0; cm_user_q <= '0; cm_keep_q <= '0; cm_last_q <= 1'b0;
            clr_busy_q <= 1'b1; clr_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_match_q <= s1_match_d; s1_phv_q <= s1_phv_d;
            valid_out_q <= valid_out_d; if_match_out_q <= if_match_out_d;
            act_addr_q <= act_addr_d; phv_out_q <= phv_out_d;
            state_q <= state_d; idx_q <= idx_d;
            seg1_data_q <= seg1_data_d; seg1_user_q <= seg1_user_d;
            seg1_keep_q <= seg1_keep_d; seg1_last_q <= seg1_last_d;
            d1_valid_q <= d1_valid_d; d1_data_q <= d1_data_d; d1_user_q <= d1_user_d;
            d1_keep_q <= d1_keep_d; d1_last_q <= d1_last_d;
            cm_valid_q <= cm_valid_d; cm_data_q <= cm_data_d; cm_user_q <= cm_user_d;
            cm_keep_q <= cm_keep_d; cm_last_q <= cm_last_d;
            clr_busy_q <= clr_busy_d; clr_cnt_q <= clr_cnt_d;
        end
    end

    assign ready_out       = ready;
    assign phv_out         = phv_out_q;
    assign act_addr_out    = act_addr_q;
    assign if_match_out    = if_match_out_q;
    assign valid_out       = valid_out_q;
    assign c_m_axis_tdata  = cm_data_q;
    assign c_m_axis_tuser  = cm_user_q;
    assign c_m_axis_tkeep  = cm_keep_q;
    assign c_m_axis_tvalid = cm_valid_q;
    assign c_m_axis_tlast  = cm_last_q;
endmodule

// File: tb/tb_match_indirection_table.sv
// Bench for match_indirection_table: vector table of lookups, scoreboard queues for lookup
// results and control pass-through, hand sequences for sweep, backpressure and invalidation.
module tb_match_indirection_table;
    localparam int DW = 256, UW = 128, KW = 32, PL = 4*8*64+256, AW = 8, EW = 8, DEPTH = 256;

    logic clk = 1'b0, rst = 1'b1;
    logic [PL-1:0] phv_in = '0, phv_out;
    logic [AW-1:0] match_addr_in = '0;
    logic if_match_in = 1'b0, valid_in = 1'b0, ready_in = 1'b1;
    logic ready_out, if_match_out, valid_out;
    logic [EW-1:0] act_addr_out;
    logic [DW-1:0] c_s_axis_tdata = '0, c_m_axis_tdata;
    logic [UW-1:0] c_s_axis_tuser = '0, c_m_axis_tuser;
    logic [KW-1:0] c_s_axis_tkeep = '0, c_m_axis_tkeep;
    logic c_s_axis_tvalid = 1'b0, c_s_axis_tlast = 1'b0, c_m_axis_tvalid, c_m_axis_tlast;

    match_indirection_table dut (
        .clk(clk), .rst(rst), .phv_in(phv_in), .match_addr_in(match_addr_in),
        .if_match_in(if_match_in), .valid_in(valid_in), .ready_out(ready_out),
        .phv_out(phv_out), .act_addr_out(act_addr_out), .if_match_out(if_match_out),
        .valid_out(valid_out), .ready_in(ready_in),
        .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser),
        .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast(c_s_axis_tlast),
        .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
        .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid),
        .c_m_axis_tlast(c_m_axis_tlast));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct { logic [AW-1:0] addr; logic match; logic [EW-1:0] act; logic hit; bit lat; int acc; } exp_t;
    typedef struct { logic [DW-1:0] d; logic [UW-1:0] u; logic l; } beat_t;
    typedef struct { logic [AW-1:0] addr; logic match; logic [EW-1:0] act; logic hit; } vec_t;
    exp_t  sb[$];
    beat_t cq[$];

    logic          stall_prev = 1'b0;
    logic [EW-1:0] held_act;
    logic          held_hit;
    logic [15:0]   held_phv;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        beat_t b;
        if (rst) return;
        if (valid_out && ready_in) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL lookup_unexpected act=%0h", act_addr_out);
            end else begin
                e = sb.pop_front();
                chk("lookup_act", act_addr_out, e.act);
                chk("lookup_hit", if_match_out, e.hit);
                chk("lookup_phv", phv_out[15:0], {e.addr, 7'd0, e.match});
                if (e.lat) chk("lookup_latency", cyc - e.acc, 2);
            end
        end
        if (valid_out && !ready_in) begin
            if (stall_prev) begin
                chk("stall_hold_act", act_addr_out, held_act);
                chk("stall_hold_hit", if_match_out, held_hit);
                chk("stall_hold_phv", phv_out[15:0], held_phv);
            end
            chk("stall_ready_low", ready_out, 0);
            held_act = act_addr_out; held_hit = if_match_out; held_phv = phv_out[15:0];
            stall_prev = 1'b1;
        end else stall_prev = 1'b0;
        if (c_m_axis_tvalid) begin
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL ctl_unexpected tdata=%0h", c_m_axis_tdata[63:0]);
            end else begin
                b = cq.pop_front();
                chk("ctl_tdata", c_m_axis_tdata[63:0] ^ c_m_axis_tdata[255:192], b.d[63:0] ^ b.d[255:192]);
                chk("ctl_tuser", c_m_axis_tuser[63:0], b.u[63:0]);
                chk("ctl_tlast", c_m_axis_tlast, b.l);
            end
        end
    endtask

    task automatic lookup(input logic [AW-1:0] a, input logic m, input logic [EW-1:0] ea,
                          input logic eh, input bit lat);
        exp_t e;
        int n;
        valid_in = 1'b1; match_addr_in = a; if_match_in = m;
        phv_in = '0; phv_in[15:0] = {a, 7'd0, m};
        n = 0;
        @(negedge clk);
        while (!ready_out && n < 2000) begin @(negedge clk); n++; end
        if (!ready_out) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%0h got ready 0 expected 1", a);
        end else begin
            e.addr = a; e.match = m; e.act = ea; e.hit = eh; e.lat = lat; e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input bit expect_out);
        beat_t b;
        c_s_axis_tdata = d; c_s_axis_tuser = d[255:128] ^ {4{32'h5a5a_0f0f}};
        c_s_axis_tkeep = '1; c_s_axis_tlast = l; c_s_axis_tvalid = 1'b1;
        if (expect_out) begin b.d = d; b.u = c_s_axis_tuser; b.l = l; cq.push_back(b); end
        @(posedge clk); #1;
        c_s_axis_tvalid = 1'b0; c_s_axis_tlast = 1'b0;
    endtask

    function automatic logic [DW-1:0] hdr(input logic [7:0] mod, input logic [3:0] rv,
                                          input logic [7:0] idx);
        logic [DW-1:0] h;
        h = '0;
        h[64 +: 16] = 16'hf2f1; h[112 +: 8] = mod; h[120 +: 4] = rv; h[124 +: 4] = 4'd1;
        h[128 +: 8] = idx;
        return h;
    endfunction

    task automatic ctl_write(input logic [7:0] idx, input logic [7:0] val);
        send_beat(256'h0123_4567, 1'b0, 1'b0);
        send_beat(hdr(8'h06, 4'd1, idx), 1'b0, 1'b0);
        send_beat({248'd0, val}, 1'b1, 1'b0);
    endtask

    vec_t tbl[8];
    int   r0, t0, n;

    initial begin
        fork forever begin @(negedge clk); monitor(); end join_none

        tbl[0] = '{8'h05, 1'b1, 8'hff, 1'b0};
        tbl[1] = '{8'h12, 1'b1, 8'h3c, 1'b1};
        tbl[2] = '{8'h12, 1'b0, 8'hff, 1'b0};
        tbl[3] = '{8'h13, 1'b1, 8'h07, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 8'ha5, 1'b1};
        tbl[5] = '{8'hff, 1'b1, 8'h01, 1'b1};
        tbl[6] = '{8'hff, 1'b0, 8'hff, 1'b0};
        tbl[7] = '{8'h14, 1'b1, 8'hff, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_out", ready_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_if_match_out", if_match_out, 0);
        chk("rst_act_addr_out", act_addr_out, 0);
        chk("rst_phv_out", |phv_out, 0);
        chk("rst_c_m_tvalid", c_m_axis_tvalid, 0);
        chk("rst_c_m_tdata", |c_m_axis_tdata, 0);
        r0 = cyc;
        rst = 1'b0;
        n = 0;
        while (!ready_out && n < 1000) begin @(negedge clk); n++; end
        chk("reset_sweep_len", cyc - r0, DEPTH);

        // program entries including both address extremes
        ctl_write(8'h12, 8'h3c);
        ctl_write(8'h13, 8'h07);
        ctl_write(8'h00, 8'ha5);
        ctl_write(8'hff, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) lookup(tbl[i].addr, tbl[i].match, tbl[i].act, tbl[i].hit, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // write immediately followed by a lookup of the same entry
        ctl_write(8'h40, 8'h99);
        lookup(8'h40, 1'b1, 8'h99, 1'b1, 1'b1);

        // invalidate keeps the neighbour
        send_beat(256'h0, 1'b0, 1'b0);
        send_beat(hdr(8'h06, 4'd2, 8'h12), 1'b1, 1'b0);
        lookup(8'h12, 1'b1, 8'hff, 1'b0, 1'b1);
        lookup(8'h13, 1'b1, 8'h07, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // another stage's write packet passes through untouched
        send_beat({8{32'hdead_beef}}, 1'b0, 1'b1);
        send_beat(hdr(8'h0e, 4'd1, 8'h13), 1'b0, 1'b1);
        send_beat({248'd0, 8'h55}, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("passthru_drained", cq.size(), 0);
        lookup(8'h13, 1'b1, 8'h07, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // backpressure with three lookups in flight
        ready_in = 1'b0;
        fork
            begin
                lookup(8'h00, 1'b1, 8'ha5, 1'b1, 1'b0);
                lookup(8'hff, 1'b1, 8'h01, 1'b1, 1'b0);
                lookup(8'h13, 1'b1, 8'h07, 1'b1, 1'b0);
            end
            begin repeat (4) @(posedge clk); #1; ready_in = 1'b1; end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("backpressure_drained", sb.size(), 0);

        // clear sweep interrupted by a write to 0x80
        send_beat(256'h0, 1'b0, 1'b0);
        send_beat(hdr(8'h06, 4'd15, 8'h00), 1'b1, 1'b0);
        t0 = cyc;
        ctl_write(8'h80, 8'h44);
        n = 0;
        while (!ready_out && n < 2000) begin @(negedge clk); n++; end
        chk("clear_sweep_len", cyc - t0, DEPTH + 1);
        @(posedge clk); #1;
        lookup(8'h80, 1'b1, 8'hff, 1'b0, 1'b1);
        lookup(8'h13, 1'b1, 8'hff, 1'b0, 1'b1);
        lookup(8'h40, 1'b1, 8'hff, 1'b0, 1'b1);
        ctl_write(8'h80, 8'h44);
        lookup(8'h80, 1'b1, 8'h44, 1'b1, 1'b1);

        repeat (8) @(posedge clk);
        #1;
        chk("lookup_queue_empty", sb.size(), 0);
        chk("ctl_queue_empty", cq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
